// File: rtl/a2d_spi_resp.sv
// SPI responder (mode 0) modelling an 8-channel 12-bit A2D converter.
// Oversamples SS_n/SCLK/MOSI on clk; answers each frame with the previous sample.
//
// state | meaning
// IDLE  | waiting for SS_n fall; MISO held low
// SHIFT | frame in progress; shifting MOSI in on SCLK rise, MISO out on SCLK fall
module a2d_spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ana_data,
  output logic [2:0]  chnl,
  output logic        cmd_vld,
  output logic        frm_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [2:0]  ss_sync;
  logic [2:0]  sclk_sync;
  logic [1:0]  mosi_sync;
  logic [15:0] tx_shft;
  logic [15:0] rx_shft;
  logic [4:0]  bit_cnt;
  logic [11:0] smpl;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

  // SS_n flops reset low so a select already asserted at reset release
  // never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 3'b000;
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign mosi_s    = mosi_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_shft <= 16'h0000;
      rx_shft <= 16'h0000;
      bit_cnt <= 5'd0;
      smpl    <= 12'h000;
      chnl    <= 3'd0;
      cmd_vld <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      cmd_vld <= 1'b0;
      frm_err <= 1'b0;
      // external mux has had one clk to follow the new chnl
      if (cmd_vld)
        smpl <= ana_data;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= {4'b0000, smpl};
            rx_shft <= 16'h0000;
            bit_cnt <= 5'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == 5'd16) begin
              chnl    <= rx_shft[13:11];
              cmd_vld <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shft <= {rx_shft[14:0], mosi_s};
            if (bit_cnt != 5'd17)
              bit_cnt <= bit_cnt + 5'd1;
          end else if (sclk_fall) begin
            tx_shft <= {tx_shft[14:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO = (state == SHIFT) & tx_shft[15];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Scoreboard bench for a2d_spi_resp: stimulus queues expected events and
// MISO words; independent monitors pop and compare.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] ana_data;
  logic [2:0]  chnl;
  logic        cmd_vld, frm_err;

  logic [11:0] tbl [8];
  logic [11:0] exp_smpl;
  logic [2:0]  exp_chnl;

  typedef struct {logic err; logic [2:0] ch;} evt_t;
  typedef struct {logic chk; logic [15:0] val;} fr_t;
  evt_t exp_evt[$];
  fr_t  exp_fr[$];

  int checks = 0;
  int failures = 0;

  a2d_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .ana_data(ana_data), .chnl(chnl), .cmd_vld(cmd_vld),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always_comb ana_data = tbl[chnl];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // event monitor: every cmd_vld/frm_err cycle must match the next expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (cmd_vld === 1'b1 || frm_err === 1'b1)) begin
      if (exp_evt.size() == 0) begin
        check("unexpected_evt", {14'h0, cmd_vld, frm_err}, 16'h0000);
      end else begin
        evt_t e;
        e = exp_evt.pop_front();
        check("evt_frm_err", {15'h0, frm_err}, {15'h0, e.err});
        check("evt_cmd_vld", {15'h0, cmd_vld}, {15'h0, ~e.err});
        check("evt_chnl", {13'h0, chnl}, {13'h0, e.ch});
      end
    end
  end

  // MISO monitor: collect the bit seen at each SCLK rise within a frame
  always begin
    logic [15:0] rx;
    int n;
    @(negedge SS_n);
    rx = 16'h0000;
    n = 0;
    while (SS_n == 1'b0) begin
      @(posedge SCLK or posedge SS_n);
      if (SS_n == 1'b0) begin
        rx = {rx[14:0], MISO};
        n++;
      end
    end
    if (exp_fr.size() == 0) begin
      check("unexpected_frame", 16'h0001, 16'h0000);
    end else begin
      fr_t f;
      f = exp_fr.pop_front();
      if (f.chk) check("miso_word", rx, f.val);
    end
  end

  task automatic frame(input logic [15:0] cmd, input int nr);
    fr_t  f;
    evt_t e;
    logic [15:0] sh;
    f.chk = (nr == 16);
    f.val = {4'h0, exp_smpl};
    exp_fr.push_back(f);
    if (nr == 16) begin
      exp_chnl = cmd[13:11];
      exp_smpl = tbl[cmd[13:11]];
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.ch = exp_chnl;
    exp_evt.push_back(e);
    sh = cmd;
    SS_n = 1'b0;
    MOSI = sh[15];
    wait_clk(4);
    for (int i = 0; i < nr; i++) begin
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
      sh = sh << 1;
      MOSI = sh[15];
      wait_clk(4);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clk(8);
    check("chnl_after_frame", {13'h0, chnl}, {13'h0, exp_chnl});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fr_t f;
    for (int i = 0; i < 8; i++) tbl[i] = 12'hFFF;
    exp_smpl = 12'h000;
    exp_chnl = 3'd0;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clk(5);
    check("rst_chnl", {13'h0, chnl}, 16'h0000);
    check("rst_miso", {15'h0, MISO}, 16'h0000);
    check("rst_cmd_vld", {15'h0, cmd_vld}, 16'h0000);
    check("rst_frm_err", {15'h0, frm_err}, 16'h0000);
    rst_n = 1'b1;
    wait_clk(5);

    // channel 6 so reset has something to clear; sample becomes FFF
    frame(16'h3000, 16);

    // reset 7 SCLK rises into a frame, SS_n held low across release
    f.chk = 1'b0; f.val = 16'h0000;
    exp_fr.push_back(f);
    SS_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 7; i++) begin
      SCLK = 1'b1; wait_clk(4); SCLK = 1'b0; wait_clk(4);
    end
    check("pre_rst_miso", {15'h0, MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("midrst_chnl", {13'h0, chnl}, 16'h0000);
    check("midrst_miso", {15'h0, MISO}, 16'h0000);
    check("midrst_cmd_vld", {15'h0, cmd_vld}, 16'h0000);
    check("midrst_frm_err", {15'h0, frm_err}, 16'h0000);
    exp_smpl = 12'h000;
    exp_chnl = 3'd0;
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      SCLK = 1'b1; wait_clk(4);
      check("held_ss_miso", {15'h0, MISO}, 16'h0000);
      SCLK = 1'b0; wait_clk(4);
    end
    SS_n = 1'b1;
    wait_clk(10);
    check("held_ss_chnl", {13'h0, chnl}, 16'h0000);

    frame(16'h1800, 16);          // ch3, returns cleared sample 0000

    tbl[5] = 12'hA5C;
    frame(16'h2800, 16);          // returns tbl[3] = FFF
    frame(16'h0000, 16);          // returns 0A5C, chnl -> 0

    for (int ch = 0; ch < 8; ch++) tbl[ch] = 12'(ch * 12'h111);
    for (int ch = 0; ch < 8; ch++) frame({2'b00, 3'(ch), 11'h000}, 16);
    frame(16'h1000, 16);          // returns tbl[7] = 777, chnl -> 2

    frame(16'h3800, 12);          // short frame: error, chnl/smpl kept
    frame(16'h0800, 16);          // returns tbl[2] = 222, chnl -> 1
    frame(16'h2000, 17);          // long frame: error
    frame(16'hC7FF, 16);          // ignored bits set; ch0, returns 111
    frame(16'h0000, 16);          // returns tbl[0] = 000

    wait_clk(20);
    check("evt_queue_empty", 16'(exp_evt.size()), 16'h0000);
    check("frame_queue_empty", 16'(exp_fr.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
